// File: rtl/stream_bucket_accumulator_pkg.sv
// Shared types and the requantisation helper for the bucket accumulator.
package sba_pkg;

    typedef enum logic [1:0] {LATENCY, ACCUM, DONE} state_t;

    // Keeps counter widths at least one bit when a dimension is 1.
    function automatic int max2(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    // Works at a fixed 64-bit width; the caller narrows the result to its
    // own precision, so one function serves every parameterisation.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] value,
        input int                 shift,
        input bit                 saturate,
        input int                 prec
    );
        logic signed [63:0] v, hi, lo;
        v  = value >>> shift;
        hi = (64'sd1 <<< (prec - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (prec - 1));
        if (saturate) begin
            if (v > hi) v = hi;
            else if (v < lo) v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/stream_bucket_accumulator_acc_requant.sv
// One accumulator element: arithmetic shift, then saturate or truncate.
module acc_requant
    import sba_pkg::*;
#(
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int SHIFT          = 0,
    parameter int SATURATE       = 1
) (
    input  logic [BIAS_PRECISION-1:0] value,
    output logic [PRECISION-1:0]      q
);

    logic signed [63:0] wide;

    assign wide = 64'(signed'(value));
    assign q    = PRECISION'(requant(wide, SHIFT, SATURATE != 0, PRECISION));

endmodule

// File: rtl/stream_bucket_accumulator.sv
// Streaming bucket accumulator: drops a latency prefix, sums beats round-robin
// into M buckets per lane over TEMP segments, and holds a requantised result.
module stream_bucket_accumulator
    import sba_pkg::*;
#(
    parameter int PRECISION       = 8,
    parameter int BIAS_PRECISION  = 32,
    parameter int NUM_FEATURES    = 1,
    parameter int M               = 6,
    parameter int TEMP            = 2,
    parameter int INITIAL_LATENCY = 4,
    parameter int SHIFT           = 0,
    parameter int SATURATE        = 1,
    parameter int CONTINUOUS      = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clr,
    input  logic                                                  ce,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [NUM_FEATURES-1:0][BIAS_PRECISION-1:0]           features,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]         out,
    output logic                                                  window_done
);

    localparam int LW = $clog2(max2(INITIAL_LATENCY));
    localparam int BW = $clog2(max2(M));
    localparam int SW = $clog2(max2(TEMP));
    localparam logic [LW-1:0] LAT_LAST = LW'((INITIAL_LATENCY > 0) ? INITIAL_LATENCY - 1 : 0);
    localparam state_t RST_STATE = (INITIAL_LATENCY == 0) ? ACCUM : LATENCY;

    state_t                                               state;
    logic [LW-1:0]                                        lat_cnt;
    logic [BW-1:0]                                        bucket;
    logic [SW-1:0]                                        seg;
    logic [NUM_FEATURES-1:0][M-1:0][BIAS_PRECISION-1:0]   acc, sum;
    logic [NUM_FEATURES-1:0][M-1:0][PRECISION-1:0]        q, rev;
    logic                                                 last_beat, accept, load;

    assign last_beat = (state == ACCUM) && (bucket == BW'(M - 1)) && (seg == SW'(TEMP - 1));
    assign in_ready  = ce && (state != DONE) && !(last_beat && out_valid && !out_ready);
    assign accept    = ce && in_valid && in_ready;
    assign load      = accept && last_beat;

    // Only the current bucket picks up the beat, so sum doubles as the next
    // accumulator value and as the final-window value including the last beat.
    always_comb begin
        sum = acc;
        for (int i = 0; i < NUM_FEATURES; i++)
            for (int b = 0; b < M; b++)
                if (bucket == BW'(b))
                    sum[i][b] = acc[i][b] + features[i];
    end

    for (genvar i = 0; i < NUM_FEATURES; i++) begin : g_lane
        for (genvar b = 0; b < M; b++) begin : g_bucket
            acc_requant #(
                .PRECISION     (PRECISION),
                .BIAS_PRECISION(BIAS_PRECISION),
                .SHIFT         (SHIFT),
                .SATURATE      (SATURATE)
            ) u_rq (
                .value(sum[i][b]),
                .q    (q[i][b])
            );
        end
    end

    always_comb begin
        rev = '0;
        for (int i = 0; i < NUM_FEATURES; i++)
            for (int j = 0; j < M; j++)
                rev[i][j] = q[i][M-1-j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RST_STATE;
            lat_cnt     <= '0;
            bucket      <= '0;
            seg         <= '0;
            acc         <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            window_done <= 1'b0;
        end else if (clr) begin
            state       <= RST_STATE;
            lat_cnt     <= '0;
            bucket      <= '0;
            seg         <= '0;
            acc         <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            window_done <= 1'b0;
        end else begin
            window_done <= load;
            if (ce) begin
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
                if (load) begin
                    out       <= rev;
                    out_valid <= 1'b1;
                end
                if (accept) begin
                    case (state)
                        LATENCY: begin
                            lat_cnt <= lat_cnt + 1'b1;
                            if (lat_cnt == LAT_LAST)
                                state <= ACCUM;
                        end
                        ACCUM: begin
                            if (last_beat) begin
                                acc    <= '0;
                                bucket <= '0;
                                seg    <= '0;
                                state  <= (CONTINUOUS != 0) ? ACCUM : DONE;
                            end else begin
                                acc <= sum;
                                if (bucket == BW'(M - 1)) begin
                                    bucket <= '0;
                                    seg    <= seg + 1'b1;
                                end else begin
                                    bucket <= bucket + 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_bucket_accumulator.sv
// Directed bench with a reference model and a result scoreboard; auxiliary
// instances cover truncation, shift and single-window mode.
module tb_stream_bucket_accumulator;
    localparam int P = 8, BP = 32, NF = 2, M = 6, T = 2, IL = 4;
    typedef logic [NF-1:0][M-1:0][P-1:0] res_t;
    typedef logic [0:0][M-1:0][P-1:0]    res1_t;

    logic clk = 1'b0;
    logic rst, clr, ce, in_valid, out_ready;
    logic [NF-1:0][BP-1:0] features;
    logic in_ready, out_valid, window_done;
    res_t out;

    logic b_clr, b_valid;
    logic [0:0][BP-1:0] b_feat;
    logic s0_rdy, s0_ov, s0_wd, sh_rdy, sh_ov, sh_wd, nc_rdy, nc_ov, nc_wd;
    res1_t s0_out, sh_out, nc_out;

    int checks, errors;

    always #5 clk = ~clk;

    stream_bucket_accumulator #(.PRECISION(P), .BIAS_PRECISION(BP), .NUM_FEATURES(NF), .M(M), .TEMP(T),
        .INITIAL_LATENCY(IL), .SHIFT(0), .SATURATE(1), .CONTINUOUS(1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .features(features), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .window_done(window_done));

    stream_bucket_accumulator #(.PRECISION(P), .BIAS_PRECISION(BP), .NUM_FEATURES(1), .M(M), .TEMP(T),
        .INITIAL_LATENCY(IL), .SHIFT(0), .SATURATE(0), .CONTINUOUS(1)) u_s0 (
        .clk(clk), .rst(rst), .clr(b_clr), .ce(1'b1), .in_valid(b_valid), .in_ready(s0_rdy),
        .features(b_feat), .out_valid(s0_ov), .out_ready(1'b1), .out(s0_out), .window_done(s0_wd));

    stream_bucket_accumulator #(.PRECISION(P), .BIAS_PRECISION(BP), .NUM_FEATURES(1), .M(M), .TEMP(T),
        .INITIAL_LATENCY(IL), .SHIFT(1), .SATURATE(1), .CONTINUOUS(1)) u_sh (
        .clk(clk), .rst(rst), .clr(b_clr), .ce(1'b1), .in_valid(b_valid), .in_ready(sh_rdy),
        .features(b_feat), .out_valid(sh_ov), .out_ready(1'b1), .out(sh_out), .window_done(sh_wd));

    stream_bucket_accumulator #(.PRECISION(P), .BIAS_PRECISION(BP), .NUM_FEATURES(1), .M(M), .TEMP(T),
        .INITIAL_LATENCY(IL), .SHIFT(0), .SATURATE(1), .CONTINUOUS(0)) u_nc (
        .clk(clk), .rst(rst), .clr(b_clr), .ce(1'b1), .in_valid(b_valid), .in_ready(nc_rdy),
        .features(b_feat), .out_valid(nc_ov), .out_ready(1'b1), .out(nc_out), .window_done(nc_wd));

    // Reference model of the main instance
    logic signed [BP-1:0] m_acc [NF][M];
    int   m_lat, m_bkt, m_seg;
    bit   m_done, m_ov, m_wd;
    res_t m_out;
    res_t sb [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] rq(input logic signed [BP-1:0] a);
        longint v;
        v = longint'(a);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[P-1:0];
    endfunction

    task automatic model_reset();
        m_lat = 0; m_bkt = 0; m_seg = 0;
        m_done = 0; m_ov = 0; m_wd = 0; m_out = '0;
        for (int i = 0; i < NF; i++)
            for (int b = 0; b < M; b++) m_acc[i][b] = '0;
    endtask

    function automatic bit exp_rdy();
        return ce && !m_done && !(m_lat >= IL && m_bkt == M-1 && m_seg == T-1 && m_ov && !out_ready);
    endfunction

    // Called just after a negedge with inputs already driven.
    task automatic cyc();
        bit acc_b, ld;
        res_t nr, e;
        #1;
        chk("in_ready", in_ready, exp_rdy());
        acc_b = ce && in_valid && exp_rdy();
        ld = 0;
        nr = '0;
        if (clr) model_reset();
        else if (ce) begin
            if (m_ov && out_ready) m_ov = 0;
            if (acc_b) begin
                if (m_lat < IL) m_lat++;
                else begin
                    for (int i = 0; i < NF; i++) m_acc[i][m_bkt] = m_acc[i][m_bkt] + features[i];
                    if (m_bkt == M-1 && m_seg == T-1) begin
                        for (int i = 0; i < NF; i++)
                            for (int j = 0; j < M; j++) nr[i][j] = rq(m_acc[i][M-1-j]);
                        sb.push_back(nr);
                        m_out = nr; m_ov = 1; ld = 1;
                        for (int i = 0; i < NF; i++)
                            for (int b = 0; b < M; b++) m_acc[i][b] = '0;
                        m_bkt = 0; m_seg = 0;
                    end else if (m_bkt == M-1) begin
                        m_bkt = 0; m_seg++;
                    end else m_bkt++;
                end
            end
        end
        m_wd = ld;
        @(posedge clk); #1;
        chk("out_valid", out_valid, m_ov);
        chk("window_done", window_done, m_wd);
        if (window_done) begin
            chk("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_out", out, e);
            end
        end
        chk("out_hold", out, m_out);
        @(negedge clk);
    endtask

    task automatic bcyc();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        res_t  er;
        res1_t e1;
        int    n;
        bit    got;
        checks = 0; errors = 0;
        rst = 1; clr = 0; ce = 1; in_valid = 0; out_ready = 1; features = '0;
        b_clr = 0; b_valid = 0; b_feat = '0;
        model_reset();
        @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_window_done", window_done, 1'b0);
        chk("rst_out", out, '0);
        chk("rst_nc_ready", nc_rdy, 1'b1);
        @(negedge clk); rst = 0;

        // Constant beats: latency prefix then three back-to-back windows
        in_valid = 1; features[0] = 1; features[1] = 3;
        repeat (IL + 3*M*T) cyc();
        for (int j = 0; j < M; j++) begin er[0][j] = 8'd2; er[1][j] = 8'd6; end
        chk("const_sum", out, er);

        // Ramp exposes bucket order and the output reversal
        for (int k = 1; k <= M*T; k++) begin
            features[0] = BP'(k); features[1] = BP'(-k); cyc();
        end
        for (int j = 0; j < M; j++) begin
            er[0][j] = 8'(2*(M-1-j) + 8); er[1][j] = 8'(-(2*(M-1-j) + 8));
        end
        chk("ramp_reversal", out, er);

        features[0] = 100; features[1] = 100;
        repeat (M*T) cyc();
        for (int j = 0; j < M; j++) begin er[0][j] = 8'd127; er[1][j] = 8'd127; end
        chk("saturate_pos", out, er);

        // Backpressure: pending result blocks only the final beat
        out_ready = 0; features[0] = 1; features[1] = 3;
        repeat (M*T - 1) cyc();
        repeat (3) cyc();
        #1 chk("bp_stall", in_ready, 1'b0);
        out_ready = 1;
        cyc();
        chk("bp_handover_valid", out_valid, 1'b1);
        for (int j = 0; j < M; j++) begin er[0][j] = 8'd2; er[1][j] = 8'd6; end
        chk("bp_window2", out, er);

        // Random clock enable after a clear
        clr = 1; cyc(); clr = 0;
        n = 0; got = 0;
        while (!got && n < 400) begin
            ce = 1'($urandom_range(0, 1));
            features[0] = (m_lat >= IL) ? BP'(m_bkt + m_seg*M + 1) : BP'(77);
            features[1] = 5;
            cyc();
            got = window_done;
            n++;
        end
        ce = 1;
        chk("ce_window_seen", got, 1'b1);
        for (int j = 0; j < M; j++) begin er[0][j] = 8'(2*(M-1-j) + 8); er[1][j] = 8'd10; end
        chk("ce_result", out, er);

        // Async reset mid-window with a pending result
        features[0] = 1; features[1] = 3;
        cyc();
        out_ready = 0;
        repeat (M*T + 3) cyc();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out", out, '0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_window_done", window_done, 1'b0);
        model_reset();
        @(negedge clk); rst = 0; out_ready = 1; in_valid = 0;

        // Truncate / shift / single-window instances
        b_valid = 1; b_feat[0] = 100;
        repeat (IL + M*T) bcyc();
        for (int j = 0; j < M; j++) e1[0][j] = 8'hC8;
        chk("truncate_out", s0_out, e1);
        chk("truncate_wd", s0_wd, 1'b1);
        for (int j = 0; j < M; j++) e1[0][j] = 8'd100;
        chk("shift_out", sh_out, e1);
        chk("shift_valid", sh_ov, 1'b1);
        for (int j = 0; j < M; j++) e1[0][j] = 8'd127;
        chk("nc_out", nc_out, e1);
        chk("nc_valid", nc_ov, 1'b1);
        chk("nc_ready_done", nc_rdy, 1'b0);
        repeat (3) bcyc();
        chk("nc_ready_stays", nc_rdy, 1'b0);
        chk("nc_drained", nc_ov, 1'b0);
        b_clr = 1; bcyc(); b_clr = 0;
        chk("nc_clr_ready", nc_rdy, 1'b1);
        b_feat[0] = 1;
        repeat (IL + M*T - 1) bcyc();
        chk("nc_latency_restart", nc_ov, 1'b0);
        bcyc();
        for (int j = 0; j < M; j++) e1[0][j] = 8'd2;
        chk("nc_restart_out", nc_out, e1);
        chk("nc_restart_wd", nc_wd, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
